mii_tx_framer: RTL and testbench
================================

# mii_tx_framer

Transmit-side MII framer draining the packet FIFO. Counts complete packets committed by the upstream writer. For each one it emits preamble and SFD, then streams FIFO bytes low-nibble-first on a 4-bit MII until the byte tagged end-of-data (EOD), then holds the inter-frame gap. The FIFO content is the complete frame including FCS; this block does no CRC or padding.

## Interface
- `PRE_NIBBLES`, default 15: number of 0x5 preamble nibbles before the SFD nibble 0xD.
- `IFG_NIBBLES`, default 24: txen-low cycles spent in IFG after the last data nibble.
- `CNT_W`, default 5: width of the pending-packet counter.
- `clkw`  in  1: clock; this is the MII TX clock, one nibble per cycle.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `pkt_commit`  in  1: one-cycle pulse from the writer; a whole packet, EOD included, is now in the FIFO.
- `fifo_do`  in  8: FIFO read data, valid the cycle after `fifo_re`, held until the next read.
- `fifo_eod`  in  1: EOD tag accompanying `fifo_do`.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_re`  out  1: FIFO read strobe.
- `mii_txd`  out  4: MII transmit nibble.
- `mii_txen`  out  1: MII transmit enable.
- `mii_txer`  out  1: MII transmit error.
- `pkt_pending`  out  CNT_W: packets committed but not yet sent.
- `busy`  out  1: high whenever state is not IDLE.
- `underrun`  out  1: one-cycle pulse when a packet is aborted.

## Operation
- Reset values: state IDLE; `pkt_pending`=0; `fifo_re`=0; `mii_txd`=0; `mii_txen`=0; `mii_txer`=0; `busy`=0; `underrun`=0.
- Asserting `rst_n` mid-frame truncates the frame at once with no txer. Pending count is lost.
- Counter rules:
  - +1 on `pkt_commit`.
  - −1 when a packet finishes, by EOD or by abort.
  - Both in the same cycle: no change.
  - Saturates at 2^CNT_W−1; a commit arriving at max is dropped. The upstream writer must not exceed this.
- FSM states: IDLE, PRE, SFD, DLO, DHI, IFG, ABORT.
- IDLE: if `pkt_pending` != 0, go to PRE next cycle.
- PRE: txen=1, txd=0x5 for `PRE_NIBBLES` cycles, then go to SFD.
- SFD: txen=1, txd=0xD.
  - If `fifo_empty`=0: `fifo_re`=1, go to DLO.
  - Else: go to ABORT.
- DLO: txen=1, txd=`fifo_do[3:0]`. Latch `fifo_do[7:4]` and `fifo_eod` into the hold register. Go to DHI.
- DHI: txen=1, txd=held high nibble.
  - Held eod=1: decrement count, go to IFG.
  - Else, `fifo_empty`=0: `fifo_re`=1, go to DLO.
  - Else: go to ABORT.
- ABORT: one cycle with txen=1, txer=1, txd=0. Pulse `underrun`, decrement count, go to IFG.
- IFG: txen=0, txd=0 for `IFG_NIBBLES` cycles, then go to IDLE.
- `fifo_re` is asserted only in SFD and DHI, and only when `fifo_empty`=0. This gives at most one read per byte, with no read-ahead past EOD.
- MII outputs decode only from state, counters, hold register and `fifo_do`. There is no combinational path from `pkt_commit` or `fifo_empty` to the MII outputs.

## Timing
- Start latency:
  - `pkt_commit` at cycle 0 → `pkt_pending`=1 at cycle 1 → PRE with txen=1 at cycle 2.
  - From idle with a packet already pending, PRE starts 1 cycle after leaving IFG.
- An N-byte packet occupies exactly PRE_NIBBLES+1+2N txen cycles: 16+2N at defaults.
- Back-to-back frames: txen stays low for IFG_NIBBLES+1 cycles (IFG plus one IDLE): 25 at defaults.
- FIFO read latency is 1 cycle. A read issued in SFD/DHI is consumed in the following DLO.
- A single-byte packet (EOD on the first byte) is legal: frame is preamble, SFD, 2 nibbles.

## Test plan
- Reset, then commit 3 bytes 0x12,0x34,0x56 (EOD on 0x56):
  - txd sequence is 0x5 ×15, 0xD, 2,1,4,3,6,5.
  - txen high for 22 cycles starting 2 cycles after commit.
  - `pkt_pending` goes 1→0 in the last DHI cycle.
- Two packets committed back-to-back: txen is low for exactly 25 cycles between the frames, and both frames are byte-exact.
- `pkt_commit` coincides with EOD consumption: `pkt_pending` stays unchanged and the second frame starts after the IFG.
- Commit with the FIFO then forced empty before the second byte:
  - first byte is sent, then one cycle of txer=1, txd=0;
  - `underrun` pulses once, `pending` decrements, IFG follows.
- `rst_n` low mid-DATA: txen=0 asynchronously, `pending`=0. After release, the block stays in IDLE until a new commit.
- 31 commits with CNT_W=5 and no draining: `pending` saturates at 31 and a 32nd commit leaves it at 31.

Source files
------------

// File: rtl/mii_tx_framer.sv
// Transmit-side MII framer: sends preamble, SFD and FIFO bytes low nibble first,
// then holds the inter-frame gap. One frame is sent per committed packet.
module mii_tx_framer #(
  parameter int unsigned PRE_NIBBLES = 15,
  parameter int unsigned IFG_NIBBLES = 24,
  parameter int unsigned CNT_W       = 5
) (
  input  logic             clkw,
  input  logic             rst_n,
  input  logic             pkt_commit,
  input  logic [7:0]       fifo_do,
  input  logic             fifo_eod,
  input  logic             fifo_empty,
  output logic             fifo_re,
  output logic [3:0]       mii_txd,
  output logic             mii_txen,
  output logic             mii_txer,
  output logic [CNT_W-1:0] pkt_pending,
  output logic             busy,
  output logic             underrun
);

  localparam int unsigned MAXN = (PRE_NIBBLES > IFG_NIBBLES) ? PRE_NIBBLES : IFG_NIBBLES;
  localparam int unsigned NW   = (MAXN > 2) ? $clog2(MAXN) : 1;
  localparam logic [NW-1:0] PRE_LAST = NW'(PRE_NIBBLES - 1);
  localparam logic [NW-1:0] IFG_LAST = NW'(IFG_NIBBLES - 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DLO,
    S_DHI,
    S_IFG,
    S_ABORT
  } state_t;

  state_t           state_q, state_d;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic [3:0]       hi_q, hi_d;
  logic             eod_q, eod_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_dec;

  always_ff @(posedge clkw or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      eod_q   <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      eod_q   <= eod_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    eod_d    = eod_q;
    pend_dec = 1'b0;
    fifo_re  = 1'b0;
    mii_txd  = '0;
    mii_txen = 1'b0;
    mii_txer = 1'b0;
    underrun = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q != '0) begin
          state_d = S_PRE;
          cnt_d   = '0;
        end
      end
      S_PRE: begin
        mii_txen = 1'b1;
        mii_txd  = 4'h5;
        if (cnt_q == PRE_LAST) begin
          state_d = S_SFD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SFD: begin
        mii_txen = 1'b1;
        mii_txd  = 4'hD;
        if (!fifo_empty) begin
          fifo_re = 1'b1;
          state_d = S_DLO;
        end else begin
          state_d = S_ABORT;
        end
      end
      S_DLO: begin
        mii_txen = 1'b1;
        mii_txd  = fifo_do[3:0];
        hi_d     = fifo_do[7:4];
        eod_d    = fifo_eod;
        state_d  = S_DHI;
      end
      S_DHI: begin
        mii_txen = 1'b1;
        mii_txd  = hi_q;
        if (eod_q) begin
          pend_dec = 1'b1;
          state_d  = S_IFG;
          cnt_d    = '0;
        end else if (!fifo_empty) begin
          fifo_re = 1'b1;
          state_d = S_DLO;
        end else begin
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        mii_txen = 1'b1;
        mii_txer = 1'b1;
        underrun = 1'b1;
        pend_dec = 1'b1;
        state_d  = S_IFG;
        cnt_d    = '0;
      end
      S_IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A commit and a finish in the same cycle cancel; a commit at the ceiling is dropped.
  always_comb begin
    pend_d = pend_q;
    if (pkt_commit && !pend_dec) begin
      if (pend_q != PEND_MAX) pend_d = pend_q + 1'b1;
    end else if (pend_dec && !pkt_commit) begin
      if (pend_q != '0) pend_d = pend_q - 1'b1;
    end
  end

  assign pkt_pending = pend_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mii_tx_framer.sv
// Scoreboard bench for mii_tx_framer: expected nibbles, frame shapes and status
// samples are queued by the stimulus and checked by a negedge monitor.
module tb_mii_tx_framer;

  logic       clkw = 1'b0;
  logic       rst_n = 1'b0;
  logic       pkt_commit = 1'b0;
  logic [7:0] fifo_do = '0;
  logic       fifo_eod = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       fifo_re;
  logic [3:0] mii_txd;
  logic       mii_txen;
  logic       mii_txer;
  logic [4:0] pkt_pending;
  logic       busy;
  logic       underrun;

  mii_tx_framer #(.PRE_NIBBLES(15), .IFG_NIBBLES(24), .CNT_W(5)) dut (
    .clkw(clkw), .rst_n(rst_n), .pkt_commit(pkt_commit),
    .fifo_do(fifo_do), .fifo_eod(fifo_eod), .fifo_empty(fifo_empty),
    .fifo_re(fifo_re), .mii_txd(mii_txd), .mii_txen(mii_txen),
    .mii_txer(mii_txer), .pkt_pending(pkt_pending), .busy(busy),
    .underrun(underrun)
  );

  always #5 clkw = ~clkw;

  typedef struct { int gap; int len; } fr_t;
  typedef struct { int kind; int tag; logic [4:0] pend; logic txen; logic busy; logic ok; } st_t;

  logic [8:0] fq[$];
  logic [4:0] nib_q[$];
  fr_t        fr_q[$];
  st_t        st_q[$];

  // FIFO model: read strobe captured mid-cycle, data presented after the next edge.
  logic re_s = 1'b0;
  always @(negedge clkw) begin
    re_s       <= fifo_re;
    fifo_empty <= (fq.size() == 0);
  end
  always @(posedge clkw) begin
    if (re_s && fq.size() > 0) {fifo_eod, fifo_do} <= fq.pop_front();
  end

  int n_cmp = 0;
  int n_bad = 0;
  int in_frame = 0;
  int flen = 0;
  int low_run = 0;
  int cur_len = -1;
  int cur_gap = -1;

  task automatic chk(input string nm, input int tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", nm, tag, got, exp);
    end
  endtask

  always @(negedge clkw) begin : mon
    logic [4:0] e;
    fr_t f;
    st_t s;
    if (mii_txen) begin
      if (in_frame == 0) begin
        in_frame = 1;
        flen = 0;
        if (fr_q.size() == 0) begin
          chk("unexpected frame", 0, 1, 0);
          cur_len = -1;
        end else begin
          f = fr_q.pop_front();
          cur_len = f.len;
          cur_gap = f.gap;
          if (cur_gap >= 0) chk("ifg length", cur_len, low_run, cur_gap);
        end
      end
      flen++;
      if (nib_q.size() == 0) begin
        chk("unexpected nibble", flen, 1, 0);
      end else begin
        e = nib_q.pop_front();
        chk("txd", flen, int'(mii_txd), int'(e[3:0]));
        chk("txer", flen, int'(mii_txer), int'(e[4]));
        chk("underrun", flen, int'(underrun), int'(e[4]));
      end
    end else begin
      if (in_frame != 0) begin
        in_frame = 0;
        if (cur_len >= 0) chk("frame length", cur_len, flen, cur_len);
        low_run = 0;
      end
      low_run++;
    end
    while (st_q.size() > 0) begin
      s = st_q.pop_front();
      case (s.kind)
        0: begin
          chk("pkt_pending", s.tag, int'(pkt_pending), int'(s.pend));
          chk("txen", s.tag, int'(mii_txen), int'(s.txen));
          chk("busy", s.tag, int'(busy), int'(s.busy));
          if (!s.txen) chk("idle outputs", s.tag, int'({mii_txd, mii_txer, underrun, fifo_re}), 0);
        end
        1: chk("wait bound", s.tag, int'(s.ok), 1);
        default: begin
          chk("leftover nibbles", s.tag, nib_q.size(), 0);
          chk("leftover frames", s.tag, fr_q.size(), 0);
          chk("frame open at end", s.tag, in_frame, 0);
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clkw);
    #1;
  endtask

  task automatic stat(input int tag, input int pend, input logic txen, input logic bsy);
    st_q.push_back('{kind: 0, tag: tag, pend: 5'(pend), txen: txen, busy: bsy, ok: 1'b0});
  endtask

  task automatic wr(input logic [7:0] b, input logic eod);
    fq.push_back({eod, b});
  endtask

  task automatic exp_pre();
    for (int i = 0; i < 15; i++) nib_q.push_back({1'b0, 4'h5});
    nib_q.push_back({1'b0, 4'hD});
  endtask

  task automatic exp_byte(input logic [7:0] b);
    nib_q.push_back({1'b0, b[3:0]});
    nib_q.push_back({1'b0, b[7:4]});
  endtask

  task automatic exp_frame(input int gap, input int len);
    fr_q.push_back('{gap: gap, len: len});
  endtask

  task automatic wait_idle(input int tag, input int bound);
    int n;
    n = 0;
    repeat (2) tick();
    while ((busy || pkt_pending != 0) && n < bound) begin
      tick();
      n++;
    end
    st_q.push_back('{kind: 1, tag: tag, pend: '0, txen: 1'b0, busy: 1'b0, ok: (n < bound)});
    stat(tag, 0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    stat(1, 0, 1'b0, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // 3-byte packet, commit sampled at P1, frame P2..P23
    wr(8'h12, 1'b0); wr(8'h34, 1'b0); wr(8'h56, 1'b1);
    exp_frame(-1, 22); exp_pre(); exp_byte(8'h12); exp_byte(8'h34); exp_byte(8'h56);
    pkt_commit = 1'b1;
    tick(); pkt_commit = 1'b0; stat(10, 1, 1'b0, 1'b0);
    tick(); stat(11, 1, 1'b1, 1'b1);
    repeat (21) tick(); stat(12, 1, 1'b1, 1'b1);
    tick(); stat(13, 0, 1'b0, 1'b1);
    wait_idle(14, 200);

    // two packets committed back to back
    wr(8'hAB, 1'b0); wr(8'hCD, 1'b1); wr(8'hEF, 1'b1);
    exp_frame(-1, 20); exp_pre(); exp_byte(8'hAB); exp_byte(8'hCD);
    exp_frame(25, 18); exp_pre(); exp_byte(8'hEF);
    pkt_commit = 1'b1;
    tick();
    tick(); pkt_commit = 1'b0; stat(20, 2, 1'b1, 1'b1);
    wait_idle(21, 300);

    // commit lands in the cycle the EOD byte's high nibble is sent
    wr(8'h9A, 1'b0); wr(8'hBC, 1'b1); wr(8'h01, 1'b1);
    exp_frame(-1, 20); exp_pre(); exp_byte(8'h9A); exp_byte(8'hBC);
    exp_frame(25, 18); exp_pre(); exp_byte(8'h01);
    pkt_commit = 1'b1;
    tick(); pkt_commit = 1'b0;
    repeat (20) tick(); pkt_commit = 1'b1; stat(30, 1, 1'b1, 1'b1);
    tick(); pkt_commit = 1'b0; stat(31, 1, 1'b0, 1'b1);
    wait_idle(32, 300);

    // FIFO runs dry after the first byte
    wr(8'hA7, 1'b0);
    exp_frame(-1, 19); exp_pre(); exp_byte(8'hA7); nib_q.push_back({1'b1, 4'h0});
    pkt_commit = 1'b1;
    tick(); pkt_commit = 1'b0;
    repeat (19) tick(); stat(40, 1, 1'b1, 1'b1);
    tick(); stat(41, 0, 1'b0, 1'b1);
    wait_idle(42, 200);

    // reset asserted in the middle of the second data byte
    wr(8'h11, 1'b0); wr(8'h22, 1'b0); wr(8'h33, 1'b0); wr(8'h44, 1'b1);
    exp_frame(-1, 18); exp_pre(); exp_byte(8'h11);
    pkt_commit = 1'b1;
    tick(); pkt_commit = 1'b0;
    repeat (19) tick();
    #2 rst_n = 1'b0;
    stat(50, 0, 1'b0, 1'b0);
    repeat (3) tick();
    fq.delete();
    rst_n = 1'b1;
    repeat (10) tick(); stat(51, 0, 1'b0, 1'b0);
    repeat (30) tick(); stat(52, 0, 1'b0, 1'b0);
    tick();

    // 32 commits while a long packet streams; count saturates at 31
    for (int i = 0; i < 40; i++) begin
      wr(8'(i * 37 + 5), (i == 39));
    end
    exp_frame(-1, 96); exp_pre();
    for (int i = 0; i < 40; i++) exp_byte(8'(i * 37 + 5));
    for (int i = 0; i < 30; i++) begin
      exp_frame(25, 17); exp_pre(); nib_q.push_back({1'b1, 4'h0});
    end
    pkt_commit = 1'b1;
    repeat (31) tick(); stat(60, 31, 1'b1, 1'b1);
    tick(); pkt_commit = 1'b0; stat(61, 31, 1'b1, 1'b1);
    wait_idle(62, 3000);

    st_q.push_back('{kind: 2, tag: 70, pend: '0, txen: 1'b0, busy: 1'b0, ok: 1'b0});
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
